// File: rtl/tdc_ctrl_pkg.sv
// rtl/tdc_ctrl_pkg.sv - shared state encoding and width helpers for the TDC measurement sequencer
package tdc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LAUNCH,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  // Width of a single tap count: 0..TAPS inclusive.
  function automatic int tap_w(input int taps);
    return $clog2(taps + 1);
  endfunction

  // Accumulator holds 2^log2_avg full-scale counts without overflow.
  function automatic int acc_w(input int taps, input int log2_avg);
    return tap_w(taps) + log2_avg;
  endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// rtl/tdc_therm2bin.sv - thermometer snapshot to tap count, flags non-clean codes
module tdc_therm2bin
  import tdc_ctrl_pkg::*;
#(
  parameter int TAPS = 32
) (
  input  logic [TAPS-1:0]        therm,
  output logic [tap_w(TAPS)-1:0] count,
  output logic                   bubble
);

  localparam int TAP_W = tap_w(TAPS);

  logic seen_zero;

  // Count the unbroken run of ones from bit0; any one past the first zero is a bubble.
  always_comb begin
    count     = '0;
    bubble    = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (!therm[i])
        seen_zero = 1'b1;
      else if (seen_zero)
        bubble = 1'b1;
      else
        count = count + TAP_W'(1);
    end
  end

endmodule

// File: rtl/tdc_measure_ctrl.sv
// rtl/tdc_measure_ctrl.sv - launch/capture sequencer averaging N TDC samples per measurement
module tdc_measure_ctrl
  import tdc_ctrl_pkg::*;
#(
  parameter int TAPS     = 32,
  parameter int SETTLE   = 4,
  parameter int LOG2_AVG = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       chan_sel,
  output logic             busy,
  output logic [1:0]       tdc_chan,
  output logic             tdc_launch,
  input  logic [TAPS-1:0]  tdc_therm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [1:0]       res_chan,
  output logic             res_bubble
);

  localparam int TAP_W  = tap_w(TAPS);
  localparam int ACC_W  = acc_w(TAPS, LOG2_AVG);
  localparam int WAIT_W = $clog2(SETTLE + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE - 1);

  state_t               state;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [ACC_W-1:0]     avg;
  logic [LOG2_AVG-1:0]  smp_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 bubble_acc;
  logic [TAP_W-1:0]     conv_count;
  logic                 conv_bubble;
  logic [CNT_W-1:0]     sat_count;

  tdc_therm2bin #(.TAPS(TAPS)) u_therm2bin (
    .therm  (tdc_therm),
    .count  (conv_count),
    .bubble (conv_bubble)
  );

  // The final sample is folded in on the way into DONE, so the result uses acc_sum, not acc.
  always_comb begin
    acc_sum   = acc + ACC_W'(conv_count);
    avg       = acc_sum >> LOG2_AVG;
    sat_count = CNT_W'(avg);
    if ((avg >> CNT_W) != '0)
      sat_count = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      tdc_chan   <= '0;
      tdc_launch <= 1'b0;
      res_valid  <= 1'b0;
      res_count  <= '0;
      res_chan   <= '0;
      res_bubble <= 1'b0;
      acc        <= '0;
      smp_cnt    <= '0;
      wait_cnt   <= '0;
      bubble_acc <= 1'b0;
    end else begin
      tdc_launch <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ARM;
            busy       <= 1'b1;
            tdc_chan   <= chan_sel;
            acc        <= '0;
            smp_cnt    <= '0;
            bubble_acc <= 1'b0;
          end
        end
        ARM: begin
          state      <= LAUNCH;
          tdc_launch <= 1'b1;
        end
        LAUNCH: begin
          state    <= WAIT;
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt == '0)
            state <= CAPTURE;
          else
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        CAPTURE: begin
          acc        <= acc_sum;
          bubble_acc <= bubble_acc | conv_bubble;
          if (&smp_cnt) begin
            state      <= DONE;
            res_valid  <= 1'b1;
            res_count  <= sat_count;
            res_chan   <= tdc_chan;
            res_bubble <= bubble_acc | conv_bubble;
          end else begin
            smp_cnt    <= smp_cnt + LOG2_AVG'(1);
            state      <= LAUNCH;
            tdc_launch <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// tb/tb_tdc_measure_ctrl.sv - table-driven self-checking bench for tdc_measure_ctrl
module tb_tdc_measure_ctrl;

  localparam int TAPS     = 32;
  localparam int CNT_W    = 8;
  localparam int PERIOD   = 6;
  localparam int N_SMP    = 8;
  localparam int VALID_AT = 1 + N_SMP * PERIOD;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       chan_sel;
  logic             busy;
  logic [1:0]       tdc_chan;
  logic             tdc_launch;
  logic [TAPS-1:0]  tdc_therm;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [1:0]       res_chan;
  logic             res_bubble;

  int n_checks = 0;
  int n_fail   = 0;

  tdc_measure_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .chan_sel   (chan_sel),
    .busy       (busy),
    .tdc_chan   (tdc_chan),
    .tdc_launch (tdc_launch),
    .tdc_therm  (tdc_therm),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_chan   (res_chan),
    .res_bubble (res_bubble)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]            chan;
    logic [7:0][TAPS-1:0]  pat;
    int                    exp_count;
    logic                  exp_bubble;
    int                    ready_delay;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge with the DUT back in IDLE.
  task automatic run_meas(input vec_t v, input string tag);
    int c, k, first_valid, bad_launch, bad_chan, bad_busy, bad_hold;
    logic [CNT_W-1:0] held_count;
    k = 0; first_valid = -1; bad_launch = 0; bad_chan = 0; bad_busy = 0; bad_hold = 0;
    res_ready = (v.ready_delay == 0);
    tdc_therm = v.pat[0];
    chan_sel  = v.chan;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    chan_sel = ~v.chan;
    c = 0;
    while (first_valid < 0 && c < 100) begin
      if (tdc_launch) begin
        if (c != 1 + PERIOD * k || k >= N_SMP) bad_launch++;
        if (k < N_SMP) tdc_therm = v.pat[k];
        k++;
      end
      if (tdc_chan !== v.chan) bad_chan++;
      if (busy !== 1'b1) bad_busy++;
      if (res_valid === 1'b1) first_valid = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check({tag, " valid_time"}, first_valid, VALID_AT);
    check({tag, " launch_count"}, k, N_SMP);
    check({tag, " launch_timing_errs"}, bad_launch, 0);
    check({tag, " tdc_chan_errs"}, bad_chan, 0);
    check({tag, " busy_errs"}, bad_busy, 0);
    check({tag, " res_count"}, res_count, v.exp_count);
    check({tag, " res_chan"}, res_chan, v.chan);
    check({tag, " res_bubble"}, res_bubble, v.exp_bubble);
    held_count = res_count;
    if (v.ready_delay > 0) begin
      for (int i = 0; i < v.ready_delay; i++) begin
        start = i[0];
        @(negedge clk);
        if (res_valid !== 1'b1 || busy !== 1'b1 || res_count !== held_count) bad_hold++;
      end
      start = 1'b0;
      check({tag, " done_hold_errs"}, bad_hold, 0);
      res_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " idle_valid"}, res_valid, 0);
    res_ready = 1'b0;
  endtask

  initial begin
    int c, bad_idle;

    vecs[0].chan = 2'd2; vecs[0].exp_count = 8; vecs[0].exp_bubble = 1'b0; vecs[0].ready_delay = 0;
    for (int i = 0; i < 8; i++) vecs[0].pat[i] = 32'h0000_00FF;
    vecs[1].chan = 2'd1; vecs[1].exp_count = 4; vecs[1].exp_bubble = 1'b0; vecs[1].ready_delay = 0;
    for (int i = 0; i < 8; i++) vecs[1].pat[i] = i[0] ? 32'h0000_001F : 32'h0000_000F;
    vecs[2].chan = 2'd3; vecs[2].exp_count = 32; vecs[2].exp_bubble = 1'b0; vecs[2].ready_delay = 0;
    for (int i = 0; i < 8; i++) vecs[2].pat[i] = 32'hFFFF_FFFF;
    vecs[3].chan = 2'd0; vecs[3].exp_count = 0; vecs[3].exp_bubble = 1'b0; vecs[3].ready_delay = 0;
    for (int i = 0; i < 8; i++) vecs[3].pat[i] = 32'h0000_0000;
    vecs[4].chan = 2'd1; vecs[4].exp_count = 3; vecs[4].exp_bubble = 1'b1; vecs[4].ready_delay = 0;
    for (int i = 0; i < 8; i++) vecs[4].pat[i] = (i == 2) ? 32'h0000_00F7 : 32'h0000_0007;
    vecs[5].chan = 2'd2; vecs[5].exp_count = 6; vecs[5].exp_bubble = 1'b0; vecs[5].ready_delay = 10;
    for (int i = 0; i < 8; i++) vecs[5].pat[i] = 32'h0000_003F;

    rst_n = 1'b0; start = 1'b1; chan_sel = 2'd3; res_ready = 1'b0; tdc_therm = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset launch", tdc_launch, 0);
    check("reset valid", res_valid, 0);
    check("reset bubble", res_bubble, 0);
    check("reset tdc_chan", tdc_chan, 0);
    check("reset res_count", res_count, 0);
    check("reset res_chan", res_chan, 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_meas(vecs[v], $sformatf("vec%0d", v));

    // Abort during WAIT of sample 3 (launched at c=19).
    tdc_therm = 32'h0000_00FF; chan_sel = 2'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 21; i++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort busy", busy, 0);
    check("abort launch", tdc_launch, 0);
    check("abort valid", res_valid, 0);
    check("abort tdc_chan", tdc_chan, 0);
    check("abort res_count", res_count, 0);
    bad_idle = 0;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0 || tdc_launch !== 1'b0) bad_idle++;
    end
    check("abort no_result_errs", bad_idle, 0);
    run_meas(vecs[1], "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
